// File: rtl/instruction_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_queue
// Brief    : RV32I fetch front end - fetch PC, combinational imem access and
//            a small PC/instruction FIFO feeding decode over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    output logic        out_misaligned
);

    localparam int              PTR_W   = $clog2(DEPTH);
    localparam int              CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [31:0]      NOP     = 32'h0000_0013;

    logic [31:0]      fetch_pc;
    logic             halted;
    logic             marker_pending;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic [31:0] entry_pc    [DEPTH];
    logic [31:0] entry_instr [DEPTH];
    logic        entry_mis   [DEPTH];

    logic pop;
    logic space;
    logic do_push;
    logic push_marker;

    always_comb begin
        pop         = out_valid & out_ready;
        space       = (count < DEPTH_C) | pop;
        // A halted fetch unit may still owe exactly one misaligned marker.
        push_marker = halted & marker_pending;
        do_push     = ~redirect_valid & space & (~halted | marker_pending);
    end

    assign imem_addr = {fetch_pc[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc       <= RESET_PC;
            halted         <= 1'b0;
            marker_pending <= 1'b0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
        end else if (redirect_valid) begin
            fetch_pc       <= redirect_pc;
            halted         <= |redirect_pc[1:0];
            marker_pending <= |redirect_pc[1:0];
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                if (push_marker) begin
                    marker_pending <= 1'b0;
                end else begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push && !pop) begin
                count <= count + CNT_ONE;
            end else if (!do_push && pop) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Payload storage needs no reset: it is only visible while count != 0.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            entry_pc[wr_ptr]    <= fetch_pc;
            entry_instr[wr_ptr] <= push_marker ? NOP : imem_instruction;
            entry_mis[wr_ptr]   <= push_marker;
        end
    end

    always_comb begin
        out_valid       = (count != '0);
        out_instruction = out_valid ? entry_instr[rd_ptr] : 32'h0;
        out_pc          = out_valid ? entry_pc[rd_ptr]    : 32'h0;
        out_misaligned  = out_valid ? entry_mis[rd_ptr]   : 1'b0;
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_queue
// Brief    : Self-checking bench: cycle vector table plus a wrap-around
//            scoreboard run on a second instance with RESET_PC near 2^32.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_queue;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance, RESET_PC = 0
    logic        reset = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_instruction;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic        out_misaligned;

    assign imem_instruction = 32'h1000_0000 + imem_addr;

    instruction_fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_instruction(imem_instruction),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .out_misaligned  (out_misaligned)
    );

    // Wrap-around instance
    logic        reset2 = 1'b1;
    logic [31:0] imem_addr2;
    logic [31:0] imem_instruction2;
    logic        out_valid2;
    logic        out_ready2 = 1'b0;
    logic [31:0] out_instruction2;
    logic [31:0] out_pc2;
    logic        out_misaligned2;

    assign imem_instruction2 = 32'h1000_0000 + imem_addr2;

    instruction_fetch_queue #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut2 (
        .clk             (clk),
        .reset           (reset2),
        .imem_addr       (imem_addr2),
        .imem_instruction(imem_instruction2),
        .redirect_valid  (1'b0),
        .redirect_pc     (32'h0),
        .out_valid       (out_valid2),
        .out_ready       (out_ready2),
        .out_instruction (out_instruction2),
        .out_pc          (out_pc2),
        .out_misaligned  (out_misaligned2)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        chk;
        logic        v;
        logic [31:0] pc;
        logic        mis;
        logic [31:0] addr;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc,
                       input logic chk, input logic v, input logic [31:0] pc, input logic mis,
                       input logic [31:0] addr);
        vec_t e;
        e.rst = rst; e.rdy = rdy; e.rv = rv; e.rpc = rpc;
        e.chk = chk; e.v = v; e.pc = pc; e.mis = mis; e.addr = addr;
        tbl.push_back(e);
    endtask

    logic [31:0] exp_q[$];

    initial begin
        //   rst rdy rv rpc            chk v  pc             mis addr
        row(1, 1, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0);
        row(1, 1, 0, 32'h0,          1, 0, 32'h0,         0, 32'h0);   // reset state
        row(0, 1, 0, 32'h0,          1, 0, 32'h0,         0, 32'h0);
        row(0, 1, 0, 32'h0,          1, 1, 32'h0,         0, 32'h4);   // first valid
        row(0, 1, 0, 32'h0,          1, 1, 32'h4,         0, 32'h8);
        row(0, 1, 0, 32'h0,          1, 1, 32'h8,         0, 32'hC);
        row(0, 1, 0, 32'h0,          1, 1, 32'hC,         0, 32'h10);
        row(1, 0, 0, 32'h0,          1, 1, 32'h10,        0, 32'h14);
        // backpressure: 5 cycles not ready
        row(0, 0, 0, 32'h0,          1, 0, 32'h0,         0, 32'h0);
        row(0, 0, 0, 32'h0,          1, 1, 32'h0,         0, 32'h4);
        row(0, 0, 0, 32'h0,          1, 1, 32'h0,         0, 32'h8);
        row(0, 0, 0, 32'h0,          1, 1, 32'h0,         0, 32'h8);
        row(0, 0, 0, 32'h0,          1, 1, 32'h0,         0, 32'h8);
        row(0, 1, 0, 32'h0,          1, 1, 32'h0,         0, 32'h8);
        row(0, 1, 0, 32'h0,          1, 1, 32'h4,         0, 32'hC);
        // redirect while full and popping
        row(0, 1, 1, 32'h90,         1, 1, 32'h8,         0, 32'h10);
        row(0, 1, 0, 32'h0,          1, 0, 32'h0,         0, 32'h90);
        row(0, 1, 0, 32'h0,          1, 1, 32'h90,        0, 32'h94);
        // misaligned redirect
        row(0, 1, 1, 32'h92,         1, 1, 32'h94,        0, 32'h98);
        row(0, 0, 0, 32'h0,          1, 0, 32'h0,         0, 32'h90);
        row(0, 0, 0, 32'h0,          1, 1, 32'h92,        1, 32'h90);
        row(0, 1, 0, 32'h0,          1, 1, 32'h92,        1, 32'h90);
        for (int k = 0; k < 9; k++)
            row(0, 1, 0, 32'h0,      1, 0, 32'h0,         0, 32'h90);
        row(0, 1, 1, 32'h100,        1, 0, 32'h0,         0, 32'h90);
        row(0, 1, 0, 32'h0,          1, 0, 32'h0,         0, 32'h100);
        row(0, 1, 0, 32'h0,          1, 1, 32'h100,       0, 32'h104);
        // reset while full
        row(0, 0, 0, 32'h0,          1, 1, 32'h104,       0, 32'h108);
        row(1, 0, 0, 32'h0,          1, 1, 32'h104,       0, 32'h10C);
        row(0, 0, 0, 32'h0,          1, 0, 32'h0,         0, 32'h0);
        // reset during a pending misaligned marker
        row(0, 0, 1, 32'h46,         1, 1, 32'h0,         0, 32'h4);
        row(1, 0, 0, 32'h0,          1, 0, 32'h0,         0, 32'h44);
        row(0, 1, 0, 32'h0,          1, 0, 32'h0,         0, 32'h0);
        row(0, 1, 0, 32'h0,          1, 1, 32'h0,         0, 32'h4);
        // back-to-back redirects: last wins
        row(0, 1, 1, 32'h200,        1, 1, 32'h4,         0, 32'h8);
        row(0, 1, 1, 32'h300,        1, 0, 32'h0,         0, 32'h200);
        row(0, 1, 0, 32'h0,          1, 0, 32'h0,         0, 32'h300);
        row(0, 1, 0, 32'h0,          1, 1, 32'h300,       0, 32'h304);

        for (int i = 0; i < tbl.size(); i++) begin
            logic [31:0] exp_instr;
            @(negedge clk);
            reset          = tbl[i].rst;
            out_ready      = tbl[i].rdy;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            #1;
            if (tbl[i].chk) begin
                exp_instr = !tbl[i].v ? 32'h0 :
                            (tbl[i].mis ? 32'h0000_0013 : 32'h1000_0000 + tbl[i].pc);
                check($sformatf("row%0d out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].v});
                check($sformatf("row%0d out_pc", i), out_pc, tbl[i].v ? tbl[i].pc : 32'h0);
                check($sformatf("row%0d out_instruction", i), out_instruction, exp_instr);
                check($sformatf("row%0d out_misaligned", i), {31'b0, out_misaligned}, {31'b0, tbl[i].mis});
                check($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].addr);
            end
        end

        // Wrap-around: scoreboard of expected PCs, popped on each handshake
        @(negedge clk);
        reset2 = 1'b1;
        @(negedge clk);
        #1;
        check("wrap reset imem_addr", imem_addr2, 32'hFFFF_FFF8);
        check("wrap reset out_valid", {31'b0, out_valid2}, 32'h0);
        @(negedge clk);
        reset2     = 1'b0;
        out_ready2 = 1'b1;
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        for (int c = 0; c < 12 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            #1;
            if (out_valid2 && out_ready2) begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("wrap out_pc", out_pc2, e);
                check("wrap out_instruction", out_instruction2, 32'h1000_0000 + e);
                check("wrap out_misaligned", {31'b0, out_misaligned2}, 32'h0);
            end
        end
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL wrap timeout: got %0d pending entries expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_queue.md
# instruction_fetch_queue

Fetch front end of the RV32I core. It owns the fetch program counter and drives the address into the combinational instruction memory. Each fetched word is captured together with its PC into a small FIFO and presented to the decode stage over a valid/ready handshake. Branch, jump and trap redirects flush the queue and restart fetch at the new target.

## Interface
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- DEPTH, 2, queue entries; power of two, at least 2.

- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  32  word-aligned fetch address to instruction memory: {fetch_pc[31:2], 2'b00}.
- imem_instruction  in  32  instruction word for imem_addr, returned in the same cycle (combinational memory).
- redirect_valid  in  1  taken branch, jump or trap this cycle.
- redirect_pc  in  32  new fetch target; sampled when redirect_valid is 1.
- out_valid  out  1  queue head holds an instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instruction  out  32  head instruction; 0 when empty.
- out_pc  out  32  PC of head instruction; 0 when empty.
- out_misaligned  out  1  head entry is an instruction-address-misaligned marker.

## Operation
- State:
  - fetch_pc (32 bits)
  - halted (1 bit)
  - DEPTH entries of {pc, instruction, misaligned}
  - read and write pointers
  - count, width clog2(DEPTH+1)
- pop = out_valid & out_ready.
- space = (count < DEPTH) | pop. A full queue accepts a push in the same cycle as a pop.
- Priority each cycle: reset > redirect > normal fetch.
- Normal fetch (no redirect, halted=0, space=1):
  - Push {fetch_pc, imem_instruction, 0}.
  - fetch_pc <= fetch_pc + 4, modulo 2^32: 32'hFFFF_FFFC wraps to 0.
- No space, or halted=1: no push; fetch_pc holds; imem_addr stays stable.
- Redirect, redirect_valid=1:
  - Any handshake on the output this cycle completes (decode consumed it). All queue entries are then discarded: count <= 0, pointers <= 0.
  - No push this cycle; imem_instruction is ignored.
  - If redirect_pc[1:0] == 0: fetch_pc <= redirect_pc; halted <= 0.
  - If redirect_pc[1:0] != 0: fetch_pc <= redirect_pc and halted <= 1. Next cycle, push one marker {redirect_pc, 32'h0000_0013 (NOP), 1}. After that, no further pushes until the next redirect or reset.
  - The marker push needs space and waits for it if the queue is full. Because the queue is empty after a redirect, it is always pushed the following cycle.
- out_* are driven combinationally from the head entry.
- count: +1 on push only, -1 on pop only, unchanged on push+pop.
- Pop with count=0 is impossible, since out_valid=0.

## Timing
- Reset values:
  - fetch_pc=RESET_PC, halted=0, count=0, pointers=0.
  - out_valid=0, out_instruction=0, out_pc=0, out_misaligned=0.
  - imem_addr=RESET_PC with bits [1:0] cleared.
- Reset asserted mid-operation discards all entries and any pending marker on that edge.
- Fetch-to-output latency: word at imem_addr in cycle N appears at the head (if the queue was empty) with out_valid=1 in cycle N+1.
- First instruction after reset release: out_valid=1 two cycles after the reset edge deasserts.
- Redirect penalty: redirect in cycle N → out_valid=0 in N+1 → target instruction valid in N+2.
- Steady state with out_ready=1 constantly: one instruction per cycle, no bubbles.
- Backpressure: out_valid and head contents hold until popped. The head may only change after a pop or a redirect.
- Redirect and reset are level-sampled each cycle. Consecutive redirects each take effect; the last one wins.

## Test plan
- Reset, out_ready=1, memory returns 32'h1000_0000+addr → out_pc sequence 0,4,8,C with matching instructions; first out_valid=1 at the 2nd cycle after reset release.
- out_ready=0 for 5 cycles → count reaches 2, fetch_pc frozen at 8, imem_addr=8. Raise out_ready → heads 0,4,8 in three consecutive cycles, no gap.
- Redirect to 32'h0000_0090 while full and out_ready=1 → head popped that cycle, queue empty next cycle, then out_pc=0x90 valid one cycle later with no stale entries.
- Redirect to 32'h0000_0092 → single entry: out_pc=0x92, out_instruction=0x00000013, out_misaligned=1. Then out_valid stays 0 for 10 cycles. Redirect to 0x100 resumes normal fetch.
- Parameter RESET_PC=32'hFFFF_FFF8 → out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
- Reset asserted while full and during a pending misaligned marker → next cycle out_valid=0, imem_addr=RESET_PC, halted cleared.
